// File: rtl/rsa_modexp_param_pkg.sv
// Shared status codes, operand select codes and FSM state encoding for the
// parametrised RSA modular-exponentiation core.
package rsa_modexp_param_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    localparam logic [1:0] SEL_M = 2'd0;
    localparam logic [1:0] SEL_E = 2'd1;
    localparam logic [1:0] SEL_D = 2'd2;
    localparam logic [1:0] SEL_N = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SQR,
        S_MUL,
        S_FIN,
        S_ERR,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/rsa_modexp_param_if.sv
// Host bus of the modexp core: operand loading, start, result readback and status.
interface rsa_modexp_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              exe;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic              mode;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] result;
    logic              oe_n;
    logic [1:0]        status;
    logic              done;

    modport master (
        output exe, addr, wen, mode, data,
        input  result, oe_n, status, done
    );

    modport slave (
        input  exe, addr, wen, mode, data,
        output result, oe_n, status, done
    );
endinterface

// File: rtl/rsa_modexp_param_modmul.sv
// Interleaved (Blakley) modular multiplier: p = a*b mod n in exactly KEY_W clock
// edges, the first of which is the start edge; o_p is valid while o_done is high.
module rsa_modexp_param_modmul
    import rsa_modexp_param_pkg::*;
#(
    parameter int KEY_W = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [KEY_W-1:0] i_a,
    input  logic [KEY_W-1:0] i_b,
    input  logic [KEY_W-1:0] i_n,
    output logic [KEY_W-1:0] o_p,
    output logic             o_done
);
    localparam int CNT_W = $clog2(KEY_W) + 1;

    logic [KEY_W-1:0] r_p;
    logic [KEY_W-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [KEY_W-1:0] w_pin;
    logic             w_bit;
    logic [KEY_W:0]   w_dbl;
    logic [KEY_W:0]   w_red1;
    logic [KEY_W:0]   w_add;
    logic [KEY_W-1:0] w_red2;

    // The start edge already performs the first iteration from P=0, so a
    // product occupies KEY_W edges with no setup cycle.
    always_comb begin
        w_pin  = r_busy ? r_p : '0;
        w_bit  = r_busy ? r_b[KEY_W-1] : i_b[KEY_W-1];
        w_dbl  = {w_pin, 1'b0};
        w_red1 = (w_dbl >= {1'b0, i_n}) ? (w_dbl - {1'b0, i_n}) : w_dbl;
        w_add  = w_bit ? (w_red1 + {1'b0, i_a}) : w_red1;
        w_red2 = (w_add >= {1'b0, i_n}) ? KEY_W'(w_add - {1'b0, i_n}) : w_add[KEY_W-1:0];
    end

    assign o_p    = w_red2;
    assign o_done = r_busy && (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (r_busy) begin
            r_p   <= w_red2;
            r_b   <= {r_b[KEY_W-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1))
                r_busy <= 1'b0;
        end else if (i_start) begin
            r_p    <= w_red2;
            r_b    <= {i_b[KEY_W-2:0], 1'b0};
            r_cnt  <= CNT_W'(KEY_W - 1);
            r_busy <= 1'b1;
        end
    end

endmodule

// File: rtl/rsa_modexp_param.sv
// RSA modular exponentiation M^(E|D) mod N with a word-addressed host bus and a
// constant-time left-to-right square-and-always-multiply exponent scan.
module rsa_modexp_param
    import rsa_modexp_param_pkg::*;
#(
    parameter int KEY_W  = 256,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    rsa_modexp_param_if.slave bus
);
    localparam int NW    = KEY_W / DATA_W;
    localparam int IDX_W = ADDR_W - 2;
    localparam int PTR_W = $clog2(KEY_W);

    state_t            r_state;
    state_t            w_next;
    logic [KEY_W-1:0]  r_m;
    logic [KEY_W-1:0]  r_e;
    logic [KEY_W-1:0]  r_d;
    logic [KEY_W-1:0]  r_n;
    logic [KEY_W-1:0]  r_r;
    logic [PTR_W-1:0]  r_ptr;
    logic              r_mode;
    logic              r_mm_run;
    logic              r_done;
    logic [DATA_W-1:0] r_result;

    logic [1:0]        w_sel;
    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_status;
    logic              w_accept;
    logic              w_err;
    logic              w_ebit;
    logic              w_mm_start;
    logic              w_mm_done;
    logic [KEY_W-1:0]  w_mm_b;
    logic [KEY_W-1:0]  w_mm_p;
    logic [DATA_W-1:0] w_word;

    assign w_sel      = bus.addr[ADDR_W-1 -: 2];
    assign w_idx      = bus.addr[IDX_W-1:0];
    assign w_err      = (r_n == '0) || (r_n == KEY_W'(1)) || (r_m >= r_n);
    assign w_ebit     = r_mode ? r_d[r_ptr] : r_e[r_ptr];
    assign w_mm_start = ((r_state == S_SQR) || (r_state == S_MUL)) && !r_mm_run;
    assign w_mm_b     = (r_state == S_MUL) ? r_m : r_r;

    rsa_modexp_param_modmul #(.KEY_W(KEY_W)) u_modmul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_mm_start),
        .i_a     (r_r),
        .i_b     (w_mm_b),
        .i_n     (r_n),
        .o_p     (w_mm_p),
        .o_done  (w_mm_done)
    );

    always_comb begin
        w_next   = r_state;
        w_status = ST_BUSY;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_status = ST_IDLE;
                w_accept = 1'b1;
                if (bus.exe) w_next = S_CHECK;
            end
            S_DONE: begin
                w_status = ST_DONE;
                w_accept = 1'b1;
                if (bus.exe) w_next = S_CHECK;
            end
            S_ERROR: begin
                w_status = ST_ERR;
                w_accept = 1'b1;
                if (bus.exe) w_next = S_CHECK;
            end
            S_CHECK: w_next = w_err ? S_ERR : S_SQR;
            S_SQR:   if (w_mm_done) w_next = S_MUL;
            S_MUL:   if (w_mm_done) w_next = (r_ptr == '0) ? S_FIN : S_SQR;
            S_FIN:   w_next = S_DONE;
            S_ERR:   w_next = S_ERROR;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_word = '0;
        for (int w = 0; w < NW; w++)
            if (w_idx == IDX_W'(w))
                w_word = r_r[w*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_m      <= '0;
            r_e      <= '0;
            r_d      <= '0;
            r_n      <= '0;
            r_r      <= '0;
            r_ptr    <= '0;
            r_mode   <= 1'b0;
            r_mm_run <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_next;
            r_done   <= (r_state == S_FIN) || (r_state == S_ERR);
            r_result <= w_word;

            if (w_accept && bus.wen) begin
                for (int w = 0; w < NW; w++) begin
                    if (w_idx == IDX_W'(w)) begin
                        case (w_sel)
                            SEL_M: r_m[w*DATA_W +: DATA_W] <= bus.data;
                            SEL_E: r_e[w*DATA_W +: DATA_W] <= bus.data;
                            SEL_D: r_d[w*DATA_W +: DATA_W] <= bus.data;
                            SEL_N: r_n[w*DATA_W +: DATA_W] <= bus.data;
                            default: ;
                        endcase
                    end
                end
            end

            if (w_accept && bus.exe)
                r_mode <= bus.mode;

            if (w_mm_start)
                r_mm_run <= 1'b1;
            else if (w_mm_done)
                r_mm_run <= 1'b0;

            // The multiply product is always computed; only the commit is bit-dependent.
            case (r_state)
                S_CHECK: begin
                    if (w_err) begin
                        r_r <= '0;
                    end else begin
                        r_r   <= KEY_W'(1);
                        r_ptr <= PTR_W'(KEY_W - 1);
                    end
                end
                S_SQR: if (w_mm_done) r_r <= w_mm_p;
                S_MUL: begin
                    if (w_mm_done) begin
                        if (w_ebit) r_r <= w_mm_p;
                        r_ptr <= r_ptr - PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.status = w_status;
    assign bus.oe_n   = (r_state != S_DONE);
    assign bus.done   = r_done;

endmodule
